// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory responder.
// Holds the responder FSM state type, byte-enable/word widths and the byte-merge helper.
package data_mem_pkg;

    localparam int BE_W   = 4;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic [WORD_W-1:0] be_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised storage with byte-enable merge on write and combinational read.
// All words clear to zero while reset is asserted (active-low, asynchronous).
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [ADDR_W-1:0] idx,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] rd_data,
    output logic [WORD_W-1:0] wr_word_d
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];

    assign rd_data   = mem_q[idx];
    assign wr_word_d = be_merge(mem_q[idx], wr_data, wr_be);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= wr_word_d;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: IDLE -> WAIT (LATENCY cycles) -> RESP.
// Define DATA_MEM_TRACE_EN to print every committed write as "@pc: *addr <= word".
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [30:0] DEPTH_W  = 31'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [31:0]       addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [31:0]       pc_q, pc_d;

    logic              addr_err;
    logic              mem_wr_en;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] wr_word;

    assign addr_err = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q[31:2]} >= DEPTH_W);

    data_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (mem_wr_en),
        .wr_be     (be_q),
        .idx       (addr_q[ADDR_W+1:2]),
        .wr_data   (wdata_q),
        .rd_data   (mem_rdata),
        .wr_word_d (wr_word)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pc_d        = pc_q;
        mem_wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    be_d    = req_be;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The access happens on the same edge that moves us to RESP.
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    rsp_err_d   = addr_err;
                    rsp_rdata_d = (addr_err || we_q) ? '0 : mem_rdata;
                    mem_wr_en   = we_q && !addr_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Request capture registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        be_q    <= be_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        pc_q    <= pc_d;
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef DATA_MEM_TRACE_EN
    always @(posedge clk) begin
        if (reset && mem_wr_en) begin
            $display("@%08h: *%08h <= %08h", pc_q, addr_q, wr_word);
        end
    end
`else
    logic unused_trace;
    assign unused_trace = ^{pc_q, wr_word};
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized traffic
// checked against a word-array model of the memory rules.
module tb_data_mem_responder;

    localparam int ADDR_W  = 12;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 1 << ADDR_W;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];

    data_mem_responder #(
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    // Applies one request to the model and returns the response it should produce.
    task automatic model_apply(input logic we, input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] exp_rdata,
                               output logic exp_err);
        logic [31:0] mask;
        int unsigned widx;
        widx      = addr >> 2;
        exp_err   = (addr % 4 != 0) || (widx >= DEPTH);
        exp_rdata = 32'h0;
        if (!exp_err) begin
            if (we) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                model_mem[widx] = (model_mem[widx] & ~mask) | (wdata & mask);
            end else begin
                exp_rdata = model_mem[widx];
            end
        end
    endtask

    // Issues one request from IDLE and completes its response handshake.
    task automatic run_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold, input logic keep_valid,
                           input logic [31:0] nxt_addr, input logic [31:0] nxt_wdata,
                           output logic [31:0] rdata, output logic err, output int edges,
                           output logic stable, output logic ok);
        int guard;
        ok = 1'b1; stable = 1'b1; rdata = 32'h0; err = 1'b0; edges = 0;
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
        req_pc = $urandom; rsp_ready = 1'b0;
        if (req_ready !== 1'b1) ok = 1'b0;
        @(posedge clk); #1;
        edges = 1;
        if (keep_valid) begin
            req_we = 1'b1; req_be = 4'hF; req_addr = nxt_addr; req_wdata = nxt_wdata;
        end else begin
            req_valid = 1'b0; req_we = 1'($urandom); req_be = 4'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
        end
        guard = 0;
        while (rsp_valid !== 1'b1 && guard < 40) begin
            if (req_ready !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
            edges++; guard++;
        end
        if (rsp_valid !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        rdata = rsp_rdata; err = rsp_err;
        repeat (hold) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err || req_ready !== 1'b0)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (rsp_valid !== 1'b0) stable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
        req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0; rsp_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%08h exp=00000000", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%0b exp=0", rsp_err); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd, er; logic e, ee, st, ok; int ed;
        model_apply(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, er, ee);
        run_txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        checks++; if (!ok || e !== 1'b0) begin failures++; $display("FAIL wr10_err got=%0b ok=%0b exp=0", e, ok); end
        run_txn(1'b0, 4'hF, 32'h10, 32'h0, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        model_apply(1'b0, 4'hF, 32'h10, 32'h0, er, ee);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd10_data got=%08h exp=deadbeef", rd); end
        checks++; if (!ok || e !== 1'b0) begin failures++; $display("FAIL rd10_err got=%0b ok=%0b exp=0", e, ok); end
        checks++; if (ed !== LATENCY + 1) begin failures++; $display("FAIL rd10_latency got=%0d exp=%0d", ed, LATENCY + 1); end
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd, er; logic e, ee, st, ok; int ed;
        model_apply(1'b1, 4'hF, 32'h20, 32'h11223344, er, ee);
        run_txn(1'b1, 4'hF, 32'h20, 32'h11223344, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        model_apply(1'b1, 4'b0010, 32'h20, 32'hAABBCCDD, er, ee);
        run_txn(1'b1, 4'b0010, 32'h20, 32'hAABBCCDD, 1, 1'b0, 0, 0, rd, e, ed, st, ok);
        run_txn(1'b0, 4'h0, 32'h20, 32'h0, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        checks++; if (!ok || rd !== 32'h1122CC44) begin failures++; $display("FAIL merge20_data got=%08h exp=1122cc44", rd); end
        // be=0 write is a legal no-op
        model_apply(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, er, ee);
        run_txn(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        checks++; if (!ok || e !== 1'b0) begin failures++; $display("FAIL be0_err got=%0b exp=0", e); end
        run_txn(1'b0, 4'h0, 32'h20, 32'h0, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        checks++; if (rd !== 32'h1122CC44) begin failures++; $display("FAIL be0_data got=%08h exp=1122cc44", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, er; logic e, ee, st, ok; int ed;
        run_txn(1'b0, 4'hF, 32'h6, 32'h0, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        checks++; if (!ok || e !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL rd6_err got err=%0b data=%08h exp err=1 data=0", e, rd); end
        run_txn(1'b0, 4'hF, 32'h4000, 32'h0, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        checks++; if (!ok || e !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL rd4000_err got err=%0b data=%08h exp err=1 data=0", e, rd); end
        run_txn(1'b1, 4'hF, 32'h12, 32'h0BADF00D, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        checks++; if (!ok || e !== 1'b1) begin failures++; $display("FAIL wr12_err got=%0b exp=1", e); end
        run_txn(1'b1, 4'hF, 32'h4010, 32'h0BADF00D, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        run_txn(1'b0, 4'hF, 32'h10, 32'h0, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL err_nowrite got=%08h exp=deadbeef", rd); end
        model_apply(1'b1, 4'hF, 32'h3FFC, 32'hCAFE0001, er, ee);
        run_txn(1'b1, 4'hF, 32'h3FFC, 32'hCAFE0001, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        run_txn(1'b0, 4'hF, 32'h3FFC, 32'h0, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        checks++; if (!ok || e !== 1'b0 || rd !== 32'hCAFE0001) begin failures++; $display("FAIL lastword got err=%0b data=%08h exp err=0 data=cafe0001", e, rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, er, nd; logic e, ee, st, ok; int ed;
        nd = $urandom;
        run_txn(1'b0, 4'hF, 32'h20, 32'h0, 5, 1'b1, 32'h40, nd, rd, e, ed, st, ok);
        checks++; if (!ok || rd !== 32'h1122CC44) begin failures++; $display("FAIL bp_data got=%08h exp=1122cc44", rd); end
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL bp_stable got=%0b exp=1", st); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_after got=%0b exp=1", req_ready); end
        model_apply(1'b1, 4'hF, 32'h40, nd, er, ee);
        run_txn(1'b1, 4'hF, 32'h40, nd, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        checks++; if (!ok || ed !== LATENCY + 1) begin failures++; $display("FAIL bp_held_latency got=%0d exp=%0d", ed, LATENCY + 1); end
        run_txn(1'b0, 4'hF, 32'h40, 32'h0, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        checks++; if (rd !== nd) begin failures++; $display("FAIL bp_held_write got=%08h exp=%08h", rd, nd); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, er; logic e, ee, st, ok, seen; int ed;
        run_txn(1'b1, 4'hF, 32'h44, 32'h12345678, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 32'h30; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL abort_accepted got=%0b exp=0", req_ready); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL abort_in_reset got ready=%0b valid=%0b exp ready=1 valid=0", req_ready, rsp_valid); end
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) seen = 1'b1; end
        @(negedge clk); reset = 1'b1;
        model_clear();
        repeat (5) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_rsp got=%0b exp=0", seen); end
        run_txn(1'b0, 4'hF, 32'h30, 32'h0, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        model_apply(1'b0, 4'hF, 32'h30, 32'h0, er, ee);
        checks++; if (!ok || rd !== er) begin failures++; $display("FAIL abort_rd30 got=%08h exp=%08h", rd, er); end
        run_txn(1'b0, 4'hF, 32'h44, 32'h0, 0, 1'b0, 0, 0, rd, e, ed, st, ok);
        model_apply(1'b0, 4'hF, 32'h44, 32'h0, er, ee);
        checks++; if (!ok || rd !== er) begin failures++; $display("FAIL reset_clears got=%08h exp=%08h", rd, er); end
    endtask

    task automatic test_random();
        logic [31:0] rd, er, addr, wd; logic e, ee, st, ok, we; logic [3:0] be;
        int ed, hold, r;
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0:       addr = $urandom_range(0, 63) * 4 + $urandom_range(1, 3);
                1:       addr = ($urandom | 32'h0001_0000) & 32'hFFFF_FFFC;
                2:       addr = 32'h0000_3FFC;
                default: addr = $urandom_range(0, 63) * 4;
            endcase
            we   = 1'($urandom);
            be   = 4'($urandom);
            wd   = $urandom;
            hold = int'($urandom_range(0, 3));
            model_apply(we, be, addr, wd, er, ee);
            run_txn(we, be, addr, wd, hold, 1'b0, 0, 0, rd, e, ed, st, ok);
            checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_timeout addr=%08h", n, addr); end
            checks++; if (rd !== er || e !== ee) begin failures++; $display("FAIL rnd%0d_rsp addr=%08h we=%0b got data=%08h err=%0b exp data=%08h err=%0b", n, addr, we, rd, e, er, ee); end
            checks++; if (ed !== LATENCY + 1 || st !== 1'b1) begin failures++; $display("FAIL rnd%0d_timing got edges=%0d stable=%0b exp edges=%0d stable=1", n, ed, st, LATENCY + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_merge();
        test_errors();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
